// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
//   Shared widths, constants and types for the pipeline stall/flush scheduler.
//   - Register-address and load-code widths plus the "no load" and
//     "register write disabled" codes used by the stage registers.
//   - Scheduler state encoding (RUN / MEM_WAIT).
//   - load_use_hit(): detects a RAW dependency between the load currently in
//     EX and the source operands of the instruction in ID.
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    localparam int BUS_ADDR_REG = 5;     // register index width
    localparam int BUS_L_CODE   = 3;     // load code width

    localparam logic [BUS_L_CODE-1:0]   LOAD_NOPE     = 3'd0;
    localparam logic                    REG_WR_DIS    = 1'b0;
    localparam logic [BUS_ADDR_REG-1:0] REG_ADDR_ZERO = 5'd0;

    typedef enum logic [0:0] {
        PIPE_RUN      = 1'b0,
        PIPE_MEM_WAIT = 1'b1
    } pipe_state_e;

    // A load in EX whose rd feeds an operand the ID instruction actually
    // reads. x0 is hard-wired to zero, so a load to x0 never creates a hazard.
    function automatic logic load_use_hit(
        input logic [BUS_L_CODE-1:0]   ex_load_code,
        input logic                    ex_reg_wr_en,
        input logic [BUS_ADDR_REG-1:0] ex_rd,
        input logic                    rs1_used,
        input logic [BUS_ADDR_REG-1:0] rs1,
        input logic                    rs2_used,
        input logic [BUS_ADDR_REG-1:0] rs2
    );
        logic is_load;
        logic writes_rd;
        is_load   = (ex_load_code != LOAD_NOPE);
        writes_rd = (ex_reg_wr_en != REG_WR_DIS) && (ex_rd != REG_ADDR_ZERO);
        return is_load && writes_rd &&
               ((rs1_used && (rs1 == ex_rd)) || (rs2_used && (rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_dff.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_dff
//   Generic W-bit register with asynchronous active-low reset to RST_VAL.
//   Ports:
//     clk    in  1  clock
//     rst_n  in  1  asynchronous active-low reset
//     d_i    in  W  next value, loaded every clock
//     q_o    out W  registered value
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl_dff #(
    parameter int            W       = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_o <= RST_VAL;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central stall/flush scheduler for the 5-stage pipeline. Every cycle it
//   decides which pipeline registers hold and which load a bubble.
//   Handled events, highest priority first: trap redirect, data-bus wait
//   state (with timeout -> bus error), taken jump/branch, load-use hazard.
//
//   Ports:
//     clk              in   1      core clock
//     rst_n            in   1      asynchronous active-low reset
//     id_rs1_addr_i    in   5      rs1 index of instruction in ID
//     id_rs2_addr_i    in   5      rs2 index of instruction in ID
//     id_rs1_used_i    in   1      ID instruction reads rs1
//     id_rs2_used_i    in   1      ID instruction reads rs2
//     ex_addr_rd_i     in   5      rd of instruction in EX
//     ex_reg_wr_en_i   in   1      EX instruction writes rd
//     ex_load_code_i   in   3      EX load code (LOAD_NOPE = not a load)
//     ex_jump_i        in   1      EX resolved a taken jump/branch
//     mem_req_i        in   1      MEM stage issues a load/store
//     mem_ack_i        in   1      data bus completes the access
//     trap_i           in   1      trap / interrupt redirect request
//     pc_hold_n_o      out  1      0 = PC holds
//     if_id_hold_n_o   out  1      0 = if_id holds
//     id_ex_hold_n_o   out  1      0 = id_ex holds
//     ex_mem_hold_n_o  out  1      0 = ex_mem holds
//     if_id_flush_o    out  1      1 = if_id loads a bubble
//     id_ex_flush_o    out  1      1 = id_ex loads a bubble
//     ex_mem_flush_o   out  1      1 = ex_mem loads a bubble
//     mem_wb_flush_o   out  1      1 = mem_wb loads a bubble
//     bus_err_o        out  1      one-cycle pulse after a MEM timeout
//     stall_cnt_o      out  CNT_W  saturating count of stall cycles
//
//   Hold/flush outputs are combinational from registered state plus the
//   current inputs so they take effect in the same cycle. The flush outputs
//   take precedence over hold_n inside the stage registers.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,   // legal 2..255
    parameter int CNT_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [BUS_ADDR_REG-1:0] id_rs1_addr_i,
    input  logic [BUS_ADDR_REG-1:0] id_rs2_addr_i,
    input  logic                    id_rs1_used_i,
    input  logic                    id_rs2_used_i,
    input  logic [BUS_ADDR_REG-1:0] ex_addr_rd_i,
    input  logic                    ex_reg_wr_en_i,
    input  logic [BUS_L_CODE-1:0]   ex_load_code_i,
    input  logic                    ex_jump_i,
    input  logic                    mem_req_i,
    input  logic                    mem_ack_i,
    input  logic                    trap_i,
    output logic                    pc_hold_n_o,
    output logic                    if_id_hold_n_o,
    output logic                    id_ex_hold_n_o,
    output logic                    ex_mem_hold_n_o,
    output logic                    if_id_flush_o,
    output logic                    id_ex_flush_o,
    output logic                    ex_mem_flush_o,
    output logic                    mem_wb_flush_o,
    output logic                    bus_err_o,
    output logic [CNT_W-1:0]        stall_cnt_o
);

    localparam int                WAIT_W    = 8;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    // ---------------- state registers ----------------
    logic [0:0]        state_raw_q;
    logic [0:0]        state_raw_d;
    pipe_state_e       state_q;
    pipe_state_e       state_d;
    logic              trap_pend_q;
    logic              trap_pend_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;
    logic              bus_err_q;
    logic              bus_err_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;

    assign state_q     = pipe_state_e'(state_raw_q);
    assign state_raw_d = state_d;

    pipe_hazard_ctrl_dff #(.W(1), .RST_VAL(PIPE_RUN)) u_state_dff (
        .clk(clk), .rst_n(rst_n), .d_i(state_raw_d), .q_o(state_raw_q)
    );
    pipe_hazard_ctrl_dff #(.W(1)) u_trap_pend_dff (
        .clk(clk), .rst_n(rst_n), .d_i(trap_pend_d), .q_o(trap_pend_q)
    );
    pipe_hazard_ctrl_dff #(.W(WAIT_W)) u_wait_cnt_dff (
        .clk(clk), .rst_n(rst_n), .d_i(wait_cnt_d), .q_o(wait_cnt_q)
    );
    pipe_hazard_ctrl_dff #(.W(1)) u_bus_err_dff (
        .clk(clk), .rst_n(rst_n), .d_i(bus_err_d), .q_o(bus_err_q)
    );
    pipe_hazard_ctrl_dff #(.W(CNT_W)) u_stall_cnt_dff (
        .clk(clk), .rst_n(rst_n), .d_i(stall_cnt_d), .q_o(stall_cnt_q)
    );

    // ---------------- combinational scheduling ----------------
    logic lu_hit;
    logic in_wait;
    logic any_hold;

    assign lu_hit = load_use_hit(ex_load_code_i, ex_reg_wr_en_i, ex_addr_rd_i,
                                 id_rs1_used_i, id_rs1_addr_i,
                                 id_rs2_used_i, id_rs2_addr_i);
    assign in_wait = (state_q == PIPE_MEM_WAIT);

    always_comb begin
        state_d         = state_q;
        trap_pend_d     = trap_pend_q;
        wait_cnt_d      = wait_cnt_q;
        bus_err_d       = 1'b0;
        pc_hold_n_o     = 1'b1;
        if_id_hold_n_o  = 1'b1;
        id_ex_hold_n_o  = 1'b1;
        ex_mem_hold_n_o = 1'b1;
        if_id_flush_o   = 1'b0;
        id_ex_flush_o   = 1'b0;
        ex_mem_flush_o  = 1'b0;
        mem_wb_flush_o  = 1'b0;

        if (in_wait && !mem_ack_i) begin
            // Still waiting on the bus: freeze everything up to MEM and keep
            // feeding bubbles into WB. A trap arriving now is remembered.
            pc_hold_n_o     = 1'b0;
            if_id_hold_n_o  = 1'b0;
            id_ex_hold_n_o  = 1'b0;
            ex_mem_hold_n_o = 1'b0;
            mem_wb_flush_o  = 1'b1;
            if (wait_cnt_q == WAIT_LAST) begin
                // Give up: report a bus error next cycle; upstream handles it
                // as a trap, so any pending trap is dropped here.
                state_d     = PIPE_RUN;
                wait_cnt_d  = '0;
                trap_pend_d = 1'b0;
                bus_err_d   = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (trap_i) begin
                    trap_pend_d = 1'b1;
                end
            end
        end else begin
            // Either running, or the ack cycle of a wait, which releases the
            // holds and re-evaluates the (previously held) EX/ID contents.
            if (in_wait) begin
                state_d     = PIPE_RUN;
                wait_cnt_d  = '0;
                trap_pend_d = 1'b0;
            end
            if (trap_i || (in_wait && trap_pend_q)) begin
                if_id_flush_o  = 1'b1;
                id_ex_flush_o  = 1'b1;
                ex_mem_flush_o = 1'b1;
            end else if (!in_wait && mem_req_i && !mem_ack_i) begin
                pc_hold_n_o     = 1'b0;
                if_id_hold_n_o  = 1'b0;
                id_ex_hold_n_o  = 1'b0;
                ex_mem_hold_n_o = 1'b0;
                mem_wb_flush_o  = 1'b1;
                state_d         = PIPE_MEM_WAIT;
                wait_cnt_d      = WAIT_W'(1);
            end else if (ex_jump_i) begin
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
            end else if (lu_hit) begin
                // Single bubble: the flushed id_ex clears the match next cycle.
                pc_hold_n_o    = 1'b0;
                if_id_hold_n_o = 1'b0;
                id_ex_flush_o  = 1'b1;
            end
        end
    end

    assign any_hold = ~(pc_hold_n_o & if_id_hold_n_o & id_ex_hold_n_o & ex_mem_hold_n_o);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (any_hold && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign bus_err_o   = bus_err_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule
